morse_sequencer: RTL and testbench

Parametrised Morse element sequencer: latches a letter pattern of up to MAX_ELEMS dots/dashes and plays it on a serial key line with standard unit timing. Dot = 1 unit on, dash = 3 units on, 1 unit gap between elements, and a 3-unit trailing letter gap. It adds a start/busy/done handshake, abort, and a one-hot element display. It sits between the switch/key input logic and the LED/buzzer outputs on the board top level.

---
 rtl/morse_pkg.sv | 27 ++
 rtl/morse_unit_tick.sv | 33 +++
 rtl/morse_sequencer.sv | 141 ++++++++++++++
 tb/tb_morse_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | morse_pkg                                                            |
// | Shared FSM state encoding and Morse unit-length constants.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package morse_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ON   = 3'd1,
    S_GAP  = 3'd2,
    S_TAIL = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [1:0] DOT_UNITS        = 2'd1;
  localparam logic [1:0] DASH_UNITS       = 2'd3;
  localparam logic [1:0] ELEM_GAP_UNITS   = 2'd1;
  localparam logic [1:0] LETTER_GAP_UNITS = 2'd3;

  function automatic logic [1:0] elem_units(input logic dash);
    return dash ? DASH_UNITS : DOT_UNITS;
  endfunction

endpackage
`default_nettype wire

// File: rtl/morse_unit_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | morse_unit_tick                                                      |
// | Prescaler: counts 0..UNIT_CYCLES-1 and flags the last cycle of unit. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module morse_unit_tick #(
  parameter int UNIT_CYCLES = 12_500_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(UNIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      cnt <= '0;
    else if (clear || tick)
      cnt <= '0;
    else
      cnt <= cnt + CNT_W'(1);
  end

  assign tick = (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/morse_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | morse_sequencer                                                      |
// | Plays a latched dot/dash pattern on a key line with unit timing.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int MAX_ELEMS   = 5,
  parameter int UNIT_CYCLES = 12_500_000,
  parameter int LEN_W       = $clog2(MAX_ELEMS + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [LEN_W-1:0]     LEN,
  input  logic [MAX_ELEMS-1:0] PATTERN,
  output logic                 MORSE_OUT,
  output logic [MAX_ELEMS-1:0] LED_ELEM,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int IDX_W = (MAX_ELEMS > 1) ? $clog2(MAX_ELEMS) : 1;
  localparam logic [LEN_W-1:0]     LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0]     LEN_MAX  = LEN_W'(MAX_ELEMS);
  localparam logic [MAX_ELEMS-1:0] ONE_HOT0 = MAX_ELEMS'(1);

  state_t               state, state_nxt;
  logic [MAX_ELEMS-1:0] pat;
  logic [LEN_W-1:0]     len_q, len_clamped;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [1:0]           units, units_nxt, cur_units;
  logic                 tick, accept, unit_done, last_elem;
  logic                 morse_nxt, busy_nxt, done_nxt;
  logic [MAX_ELEMS-1:0] led_nxt;

  // Prescaler is held at zero while idle so the first unit is full length.
  morse_unit_tick #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .clear(state == S_IDLE),
    .tick (tick)
  );

  assign len_clamped = (LEN > LEN_MAX) ? LEN_MAX : LEN;
  assign accept      = (state == S_IDLE) && START && !ABORT;
  assign last_elem   = ((LEN_W'(idx) + LEN_ONE) == len_q);

  always_comb begin
    cur_units = DOT_UNITS;
    case (state)
      S_ON:    cur_units = elem_units(pat[idx]);
      S_GAP:   cur_units = ELEM_GAP_UNITS;
      S_TAIL:  cur_units = LETTER_GAP_UNITS;
      default: cur_units = DOT_UNITS;
    endcase
  end

  assign unit_done = tick && (units == cur_units - 2'd1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      idx       <= '0;
      units     <= '0;
      MORSE_OUT <= 1'b0;
      LED_ELEM  <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      units     <= units_nxt;
      MORSE_OUT <= morse_nxt;
      LED_ELEM  <= led_nxt;
      BUSY      <= busy_nxt;
      DONE      <= done_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pat   <= '0;
      len_q <= '0;
    end else if (accept) begin
      pat   <= PATTERN;
      len_q <= len_clamped;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    units_nxt = units;
    if (state != S_IDLE && ABORT) begin
      state_nxt = S_IDLE;
      idx_nxt   = '0;
      units_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            idx_nxt   = '0;
            units_nxt = '0;
            state_nxt = (len_clamped == '0) ? S_FIN : S_ON;
          end
        end
        S_ON, S_GAP, S_TAIL: begin
          if (tick)
            units_nxt = unit_done ? 2'd0 : units + 2'd1;
          if (unit_done) begin
            if (state == S_ON)
              state_nxt = last_elem ? S_TAIL : S_GAP;
            else if (state == S_GAP) begin
              state_nxt = S_ON;
              idx_nxt   = idx + IDX_W'(1);
            end else
              state_nxt = S_FIN;
          end
        end
        S_FIN:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registers line up with it.
  always_comb begin
    morse_nxt = (state_nxt == S_ON);
    led_nxt   = (state_nxt == S_ON) ? (ONE_HOT0 << idx_nxt) : '0;
    busy_nxt  = (state_nxt == S_ON) || (state_nxt == S_GAP) || (state_nxt == S_TAIL);
    done_nxt  = (state_nxt == S_FIN);
  end

endmodule
`default_nettype wire

// File: tb/tb_morse_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_morse_sequencer                                                   |
// | Directed timeline bench for morse_sequencer (UNIT_CYCLES 4 and 1).   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_morse_sequencer;

  localparam int MAX_ELEMS = 5;
  localparam int LEN_W     = $clog2(MAX_ELEMS + 1);

  logic clk = 1'b0;
  logic rst;
  logic start, abort;
  logic [LEN_W-1:0] len;
  logic [4:0] pattern;
  logic morse_out, busy, done;
  logic [4:0] led_elem;
  logic start1, abort1;
  logic [LEN_W-1:0] len1;
  logic [4:0] pattern1;
  logic morse_out1, busy1, done1;
  logic [4:0] led_elem1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  morse_sequencer #(.MAX_ELEMS(MAX_ELEMS), .UNIT_CYCLES(4)) dut (
    .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .LEN(len),
    .PATTERN(pattern), .MORSE_OUT(morse_out), .LED_ELEM(led_elem),
    .BUSY(busy), .DONE(done)
  );

  morse_sequencer #(.MAX_ELEMS(MAX_ELEMS), .UNIT_CYCLES(1)) dut1 (
    .CLK(clk), .RST(rst), .START(start1), .ABORT(abort1), .LEN(len1),
    .PATTERN(pattern1), .MORSE_OUT(morse_out1), .LED_ELEM(led_elem1),
    .BUSY(busy1), .DONE(done1)
  );

  // Packed view {MORSE_OUT, LED_ELEM, BUSY, DONE}
  function automatic logic [7:0] obs();
    return {morse_out, led_elem, busy, done};
  endfunction

  function automatic logic [7:0] obs1();
    return {morse_out1, led_elem1, busy1, done1};
  endfunction

  // Letter 'A' (dot dash) with UNIT_CYCLES=4, START accepted at cycle 0
  function automatic logic [7:0] exp_a(int c);
    logic m;
    logic [4:0] l;
    m = (c >= 1 && c <= 4) || (c >= 9 && c <= 20);
    l = (c >= 1 && c <= 4) ? 5'b00001 : ((c >= 9 && c <= 20) ? 5'b00010 : 5'b00000);
    return {m, l, (c >= 1 && c <= 32), (c == 33)};
  endfunction

  // Digit '5' (five dots) with UNIT_CYCLES=4
  function automatic logic [7:0] exp_five(int c);
    logic m;
    logic [4:0] l;
    logic [4:0] one;
    int k;
    one = 5'b00001;
    k   = (c - 1) / 8;
    m   = (c >= 1) && (k < 5) && (((c - 1) % 8) < 4);
    l   = m ? (one << k) : 5'b00000;
    return {m, l, (c >= 1 && c <= 48), (c == 49)};
  endfunction

  // Letter 'A' with UNIT_CYCLES=1
  function automatic logic [7:0] exp_u1(int c);
    logic m;
    logic [4:0] l;
    m = (c == 1) || (c >= 3 && c <= 5);
    l = (c == 1) ? 5'b00001 : ((c >= 3 && c <= 5) ? 5'b00010 : 5'b00000);
    return {m, l, (c >= 1 && c <= 8), (c == 9)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Current cycle is cycle 0; returns in cycle 1.
  task automatic pulse_start(input logic [LEN_W-1:0] l, input logic [4:0] p);
    start   = 1'b1;
    len     = l;
    pattern = p;
    step();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0; abort = 1'b0; len = '0; pattern = '0;
    start1 = 1'b0; abort1 = 1'b0; len1 = '0; pattern1 = '0;
    #1;
    vectors++;
    if (obs() !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_hold: got %b want %b", obs(), 8'h00);
    end
    step(); step();
    rst = 1'b0;
    step();
    vectors++;
    if (obs() !== 8'h00 || obs1() !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_release: got %b/%b want 0/0", obs(), obs1());
    end
  endtask

  task automatic test_letter_a();
    pulse_start(3'd2, 5'b00010);
    for (int c = 1; c <= 36; c++) begin
      vectors++;
      if (obs() !== exp_a(c)) begin
        miscompares++;
        $display("FAIL letter_a c%0d: got %b want %b", c, obs(), exp_a(c));
      end
      step();
    end
  endtask

  task automatic test_five();
    pulse_start(3'd5, 5'b00000);
    for (int c = 1; c <= 52; c++) begin
      vectors++;
      if (obs() !== exp_five(c)) begin
        miscompares++;
        $display("FAIL five c%0d: got %b want %b", c, obs(), exp_five(c));
      end
      step();
    end
  endtask

  task automatic test_len_clamp();
    pulse_start(3'd7, 5'b00000);
    for (int c = 1; c <= 52; c++) begin
      vectors++;
      if (obs() !== exp_five(c)) begin
        miscompares++;
        $display("FAIL len7 c%0d: got %b want %b", c, obs(), exp_five(c));
      end
      step();
    end
  endtask

  task automatic test_len_zero();
    logic [7:0] e;
    pulse_start(3'd0, 5'b11111);
    for (int c = 1; c <= 4; c++) begin
      e = (c == 1) ? 8'b0000_0001 : 8'b0000_0000;
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL len0 c%0d: got %b want %b", c, obs(), e);
      end
      step();
    end
  endtask

  task automatic test_abort();
    pulse_start(3'd2, 5'b00010);
    for (int c = 1; c <= 10; c++) begin
      vectors++;
      if (obs() !== exp_a(c)) begin
        miscompares++;
        $display("FAIL abort_pre c%0d: got %b want %b", c, obs(), exp_a(c));
      end
      if (c == 10) abort = 1'b1;
      step();
    end
    abort = 1'b0;
    for (int c = 11; c <= 12; c++) begin
      vectors++;
      if (obs() !== 8'h00) begin
        miscompares++;
        $display("FAIL abort_idle c%0d: got %b want %b", c, obs(), 8'h00);
      end
      if (c == 12) pulse_start(3'd2, 5'b00010);
      else step();
    end
    for (int c = 13; c <= 48; c++) begin
      vectors++;
      if (obs() !== exp_a(c - 12)) begin
        miscompares++;
        $display("FAIL abort_restart c%0d: got %b want %b", c, obs(), exp_a(c - 12));
      end
      step();
    end
  endtask

  task automatic test_start_ignored();
    pulse_start(3'd2, 5'b00010);
    for (int c = 1; c <= 36; c++) begin
      if (c == 7) begin
        start = 1'b0;
        len = 3'd5;
        pattern = 5'b11111;
      end
      vectors++;
      if (obs() !== exp_a(c)) begin
        miscompares++;
        $display("FAIL start_busy c%0d: got %b want %b", c, obs(), exp_a(c));
      end
      if (c == 6) begin
        start = 1'b1;
        len = 3'd5;
        pattern = 5'b11111;
      end
      step();
    end
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1; abort = 1'b1; len = 3'd2; pattern = 5'b00010;
    step();
    start = 1'b0; abort = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      vectors++;
      if (obs() !== 8'h00) begin
        miscompares++;
        $display("FAIL start_abort c%0d: got %b want %b", c, obs(), 8'h00);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    pulse_start(3'd2, 5'b00010);
    for (int c = 1; c <= 6; c++) step();
    vectors++;
    if (obs() !== exp_a(7)) begin
      miscompares++;
      $display("FAIL rst_pre: got %b want %b", obs(), exp_a(7));
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (obs() !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_async: got %b want %b", obs(), 8'h00);
    end
    step(); step();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      vectors++;
      if (obs() !== 8'h00) begin
        miscompares++;
        $display("FAIL rst_after c%0d: got %b want %b", c, obs(), 8'h00);
      end
    end
  endtask

  task automatic test_unit1();
    start1 = 1'b1; len1 = 3'd2; pattern1 = 5'b00010;
    step();
    start1 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      vectors++;
      if (obs1() !== exp_u1(c)) begin
        miscompares++;
        $display("FAIL unit1 c%0d: got %b want %b", c, obs1(), exp_u1(c));
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    pulse_start(3'd2, 5'b00010);
    for (int c = 1; c <= 33; c++) step();
    pulse_start(3'd2, 5'b00010);
    for (int c = 1; c <= 36; c++) begin
      vectors++;
      if (obs() !== exp_a(c)) begin
        miscompares++;
        $display("FAIL back_to_back c%0d: got %b want %b", c, obs(), exp_a(c));
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_letter_a();
    test_five();
    test_len_clamp();
    test_len_zero();
    test_abort();
    test_start_ignored();
    test_start_abort_idle();
    test_reset_mid();
    test_unit1();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
